// File: rtl/prog_dump_fsm.sv
// -----------------------------------------------------------------------------
// prog_dump_fsm
//
// Streams the contents of program memory out through a byte-wide UART TX.
// On a start request the block sends one header byte (the word count), then
// reads words 0..n_words-1 from byte addresses 0, 4, 8, ... and sends each
// word most-significant byte first. Each byte is handed to the UART with a
// one-cycle tx_start and the block waits for tx_done before moving on.
//
// Ports
//   clk        in   rising-edge clock
//   arst_n     in   asynchronous active-low reset
//   start      in   one-cycle dump request (honoured only in IDLE)
//   n_words    in   number of words to dump, sampled with start
//   rd_en      out  memory read strobe (one cycle per word)
//   rd_addr    out  memory byte address
//   rd_data    in   memory read data, valid the cycle after rd_en
//   tx_start   out  one-cycle pulse starting one UART byte
//   tx_data    out  byte to transmit, stable until the matching tx_done
//   tx_done    in   one-cycle pulse from the UART when the byte is finished
//   busy       out  dump in progress
//   dump_done  out  one-cycle pulse at the end of a dump
// -----------------------------------------------------------------------------
module prog_dump_fsm #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTPUT_BYTE = 8,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [OUTPUT_BYTE-1:0] n_words,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   tx_start,
  output logic [OUTPUT_BYTE-1:0] tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   dump_done
);

  localparam int BYTES = DATA_WIDTH / OUTPUT_BYTE;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]       IDX_ONE     = IDX_W'(1);
  localparam logic [ADDR_WIDTH-1:0]  WORD_STRIDE = ADDR_WIDTH'(BYTES);
  localparam logic [OUTPUT_BYTE-1:0] CNT_ONE     = OUTPUT_BYTE'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CNT,
    WAIT_CNT,
    RD_REQ,
    RD_WAIT,
    SEND_BYTE,
    WAIT_TX,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [OUTPUT_BYTE-1:0] r_nwords;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [OUTPUT_BYTE-1:0] r_word_cnt;
  logic [DATA_WIDTH-1:0]  r_word;
  logic [IDX_W-1:0]       r_byte_idx;

  logic                   w_load;
  logic                   w_capture;
  logic                   w_next_byte;
  logic                   w_next_word;
  logic                   w_last_word;
  logic [OUTPUT_BYTE-1:0] w_cur_byte;

  // n_words==0 never reaches WAIT_TX, so the wrapped n_words-1 is never used.
  assign w_last_word = (r_word_cnt == (r_nwords - CNT_ONE));
  assign rd_addr     = r_addr;

  // Byte index 0 selects the most significant byte of the word.
  always_comb begin
    w_cur_byte = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (r_byte_idx == IDX_W'(i))
        w_cur_byte = r_word[DATA_WIDTH-1-i*OUTPUT_BYTE -: OUTPUT_BYTE];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    tx_start    = 1'b0;
    tx_data     = '0;
    busy        = 1'b1;
    dump_done   = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_next_byte = 1'b0;
    w_next_word = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SEND_CNT;
        end
      end
      SEND_CNT: begin
        tx_start    = 1'b1;
        tx_data     = r_nwords;
        w_state_nxt = WAIT_CNT;
      end
      WAIT_CNT: begin
        tx_data = r_nwords;
        if (tx_done) w_state_nxt = (r_nwords == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        rd_en       = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = SEND_BYTE;
      end
      SEND_BYTE: begin
        tx_start    = 1'b1;
        tx_data     = w_cur_byte;
        w_state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        tx_data = w_cur_byte;
        if (tx_done) begin
          if (r_byte_idx != LAST_IDX) begin
            w_next_byte = 1'b1;
            w_state_nxt = SEND_BYTE;
          end else if (w_last_word) begin
            w_state_nxt = DONE;
          end else begin
            w_next_word = 1'b1;
            w_state_nxt = RD_REQ;
          end
        end
      end
      DONE: begin
        busy        = 1'b0;
        dump_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_nwords   <= '0;
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_load) begin
        r_nwords   <= n_words;
        r_addr     <= '0;
        r_word_cnt <= '0;
      end
      // rd_data is valid during RD_WAIT, one cycle after the read strobe.
      if (w_capture) begin
        r_word     <= rd_data;
        r_byte_idx <= '0;
      end
      if (w_next_byte) r_byte_idx <= r_byte_idx + IDX_ONE;
      if (w_next_word) begin
        r_addr     <= r_addr + WORD_STRIDE;
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_prog_dump_fsm.sv
// -----------------------------------------------------------------------------
// tb_prog_dump_fsm
//
// Randomized bench for prog_dump_fsm. A stimulus process computes the
// expected byte stream and read addresses of each dump from the memory image
// and pushes them into queues; a monitor process (which also models the
// memory and a UART TX with programmable tx_done latency) pops and compares
// whenever the DUT strobes tx_start or rd_en.
// -----------------------------------------------------------------------------
module tb_prog_dump_fsm;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n_words = '0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        dump_done;

  prog_dump_fsm #(
    .DATA_WIDTH (32),
    .OUTPUT_BYTE(8),
    .ADDR_WIDTH (10)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .n_words  (n_words),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         gap;   // required tx_start-to-tx_start distance, 0 = unchecked
  } exp_t;

  logic [31:0] mem [256];
  exp_t        exp_q[$];
  int          addr_q[$];

  int      total = 0;
  int      bad = 0;
  int      tx_lat = 10;
  bit      spur_en = 1'b0;
  int      done_cnt = 0;
  int      n_bytes = 0;
  longint  cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor + memory model + UART TX model, all evaluated at the falling edge.
  initial begin : mon
    bit         pending;
    int         rem;
    bit         prev_rd;
    bit         rd_wait_now;
    logic [9:0] prev_addr;
    logic [7:0] cur;
    longint     last_start;
    longint     last_done;
    exp_t       e;
    pending = 0; rem = 0; prev_rd = 0; prev_addr = '0; cur = '0;
    last_start = 0; last_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!arst_n) begin
        pending = 0;
        prev_rd = 0;
        tx_done = 1'b0;
        continue;
      end
      // Memory: data appears the cycle after the read strobe, junk otherwise.
      rd_wait_now = prev_rd;
      rd_data     = prev_rd ? mem[prev_addr[9:2]] : $urandom();
      prev_rd     = rd_en;
      prev_addr   = rd_addr;
      if (rd_en) begin
        if (addr_q.size() == 0) fail_now("unexpected_rd_en");
        else                    chk("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
        if (tx_start) fail_now("rd_en_with_tx_start");
      end
      // UART TX: tx_done exactly tx_lat cycles after tx_start.
      tx_done = 1'b0;
      if (pending) begin
        chk("tx_data_stable", 64'(tx_data), 64'(cur));
        chk("no_tx_start_while_waiting", 64'(tx_start), 64'd0);
        rem--;
        if (rem == 0) begin
          tx_done   = 1'b1;
          pending   = 0;
          last_done = cyc;
        end
      end else if (tx_start) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_tx_start");
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 64'(tx_data), 64'(e.b));
          if (e.gap > 0) chk("tx_gap", 64'(cyc - last_start), 64'(e.gap));
        end
        chk("busy_during_tx", 64'(busy), 64'd1);
        cur        = tx_data;
        last_start = cyc;
        pending    = 1;
        rem        = tx_lat;
      end else if (spur_en && (rd_wait_now || $urandom_range(0, 7) == 0)) begin
        tx_done = 1'b1;   // spurious pulse while the DUT is not waiting for one
      end
      if (dump_done) begin
        done_cnt++;
        chk("done_one_after_txdone", 64'(cyc - last_done), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        chk("bytes_all_sent", 64'(exp_q.size()), 64'd0);
        chk("reads_all_done", 64'(addr_q.size()), 64'd0);
      end
    end
  end

  // Reference: header byte n, then every word k at address 4k, MSB first.
  task automatic build_exp(input int n, input int lat);
    exp_t e;
    e.b = 8'(n); e.gap = 0;
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(4 * k);
      for (int j = 0; j < 4; j++) begin
        e.b   = 8'(mem[k] >> (24 - 8 * j));
        e.gap = (j == 0) ? lat + 3 : lat + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start   = 1'b1;
    n_words = 8'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    n_words = 8'($urandom());
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("header_tx_start", 64'(tx_start), 64'd1);
  endtask

  task automatic run_dump(input int n, input int lat, input bit spur, input bit restart);
    int prev;
    int budget;
    int b0;
    tx_lat  = lat;
    spur_en = spur;
    prev    = done_cnt;
    b0      = n_bytes;
    budget  = (4 * n + 1) * (lat + 4) + 50;
    build_exp(n, lat);
    pulse_start(n);
    for (int c = 0; c < budget && done_cnt == prev; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart && busy && $urandom_range(0, 15) == 0) begin
        start   = 1'b1;
        n_words = 8'($urandom());
      end
    end
    start = 1'b0;
    chk("dump_finished", 64'(done_cnt), 64'(prev + 1));
    chk("byte_count", 64'(n_bytes - b0), 64'(4 * n + 1));
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("single_done_pulse", 64'(done_cnt), 64'(prev + 1));
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},     64'(rd_en),     64'd0);
    chk({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
    chk({tag, "_tx_start"},  64'(tx_start),  64'd0);
    chk({tag, "_tx_data"},   64'(tx_data),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_dump_done"}, 64'(dump_done), 64'd0);
  endtask

  initial begin : stim
    int prev;
    int b0;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    arst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Known two-word dump with a 10-cycle UART
    run_dump(2, 10, 1'b0, 1'b0);
    // Empty dump: header only, no reads
    run_dump(0, 3, 1'b0, 1'b0);
    // Ignored restarts and spurious tx_done
    run_dump(4, 2, 1'b1, 1'b1);
    // Random dumps
    for (int t = 0; t < 4; t++)
      run_dump($urandom_range(1, 6), $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1);
    // Full-range dump reaches address 1016
    run_dump(255, 1, 1'b1, 1'b1);

    // Reset during byte 2 of word 1 (the 8th byte of the dump)
    tx_lat  = 4;
    spur_en = 1'b0;
    prev    = done_cnt;
    b0      = n_bytes;
    build_exp(3, 4);
    pulse_start(3);
    k = 0;
    while (n_bytes - b0 < 8 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_byte8", 64'(n_bytes - b0), 64'd8);
    #3;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_on_abort", 64'(done_cnt), 64'(prev));
    exp_q.delete();
    addr_q.delete();
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_abort", 64'(busy), 64'd0);
    run_dump(3, 5, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
